// File: rtl/depack_pkg.sv
// depack_pkg: shared definitions for the multi-channel depacketizer.
//   - header field offsets (valid bit, channel field LSB)
//   - FSM state enum
//   - err_o bit indices
// The length-field LSB depends on CHAN_BITS, so it is a helper function.
package depack_pkg;

  localparam int HDR_VALID_BIT = 0;
  localparam int HDR_CHAN_LSB  = 1;

  localparam int ERR_BAD_LEN  = 0;
  localparam int ERR_BAD_CHAN = 1;
  localparam int ERR_OVERFLOW = 2;
  localparam int ERR_W        = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    DISCARD  = 2'd2
  } depack_state_e;

  // The length field sits directly above the channel field.
  function automatic int hdr_len_lsb(input int chan_bits);
    return HDR_CHAN_LSB + chan_bits;
  endfunction

endpackage

// File: rtl/depacketizer_mc_if.sv
// depacketizer_mc_if: link-side and channel-side signals of depacketizer_mc.
//   packet_i          link packet, one per cycle
//   packet_af_o       almost full, sender must not start a new header
//   payload_o         head entry of every channel buffer, channel c in slice c
//   payload_valid_o   per-channel buffer non-empty
//   payload_ready_i   per-channel pop request
//   packet_received_o one-cycle pulse per stored payload
//   err_o             {overflow, bad_chan, bad_len}
//   err_clr_i         clears err_o
// Modports: slave = depacketizer, master = link sender / consumer.
interface depacketizer_mc_if #(
  parameter int PAYLOAD_WIDTH = 128,
  parameter int PACKET_WIDTH  = 16,
  parameter int N_CHAN        = 2
);
  logic [PACKET_WIDTH-1:0]         packet_i;
  logic                            packet_af_o;
  logic [N_CHAN*PAYLOAD_WIDTH-1:0] payload_o;
  logic [N_CHAN-1:0]               payload_valid_o;
  logic [N_CHAN-1:0]               payload_ready_i;
  logic                            packet_received_o;
  logic [2:0]                      err_o;
  logic                            err_clr_i;

  modport slave (
    input  packet_i, payload_ready_i, err_clr_i,
    output packet_af_o, payload_o, payload_valid_o, packet_received_o, err_o
  );

  modport master (
    output packet_i, payload_ready_i, err_clr_i,
    input  packet_af_o, payload_o, payload_valid_o, packet_received_o, err_o
  );
endinterface

// File: rtl/depack_chan_fifo.sv
// depack_chan_fifo: single-clock first-word-fall-through circular buffer.
//   clk, reset  clock, synchronous active-high reset (clears storage too)
//   push_i      write data_i; caller only pushes when not full or popping
//   data_i      entry to write
//   pop_i       remove head entry (ignored when empty)
//   data_o      head entry, valid_o high when non-empty
//   full_o      DEPTH entries held
//   occ_o       occupancy 0..DEPTH
module depack_chan_fifo #(
  parameter int PAYLOAD_WIDTH = 128,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [PAYLOAD_WIDTH-1:0]     data_i,
  input  logic                         pop_i,
  output logic [PAYLOAD_WIDTH-1:0]     data_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_q;
  logic [PTR_W-1:0]         rd_q;
  logic [OCC_W-1:0]         occ_q;
  logic                     pop_ok_s;

  // Pointers wrap explicitly at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH-1)) return '0;
    else                      return p + 1'b1;
  endfunction

  assign pop_ok_s = pop_i && (occ_q != '0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_ok_s) rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_ok_s})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign valid_o = (occ_q != '0);
  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign occ_o   = occ_q;

endmodule

// File: rtl/depacketizer_mc.sv
// depacketizer_mc: reassembles header + N_PKTS data packets into one
// PAYLOAD_WIDTH word and steers it into the channel named by the header.
//   clk, reset  single clock, synchronous active-high reset
//   bus         depacketizer_mc_if.slave (packet in, per-channel FWFT out,
//               almost-full, receive pulse, error flags)
// Optional feature macro: DEPACK_ERR_STATUS_EN. When defined, err_o holds
// sticky {overflow, bad_chan, bad_len} flags cleared by err_clr_i (clear
// wins over set). When undefined, err_o stays 0; dropping is unchanged.
module depacketizer_mc
  import depack_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = 128,
  parameter int PACKET_WIDTH  = 16,
  parameter int N_CHAN        = 2,
  parameter int CHAN_BITS     = 1,
  parameter int N_PKTS_BITS   = 4,
  parameter int DEPTH         = 4,
  parameter int AF_LVL        = 1
) (
  input logic              clk,
  input logic              reset,
  depacketizer_mc_if.slave bus
);
  localparam int N_PKTS  = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int LEN_LSB = hdr_len_lsb(CHAN_BITS);
  localparam int OCC_W   = $clog2(DEPTH+1);
`ifdef DEPACK_ERR_STATUS_EN
  localparam logic [ERR_W-1:0] ERR_MASK = 3'b111;
`else
  localparam logic [ERR_W-1:0] ERR_MASK = 3'b000;
`endif

  depack_state_e            state_q, state_d;
  logic [N_PKTS_BITS-1:0]   cnt_q, cnt_d;
  logic [N_PKTS_BITS-1:0]   idx_q, idx_d;
  logic [CHAN_BITS-1:0]     chan_q, chan_d;
  logic [PAYLOAD_WIDTH-1:0] asm_q, asm_d;
  logic                     recv_q;
  logic [ERR_W-1:0]         err_q, err_d;

  logic                     hdr_valid_s;
  logic [CHAN_BITS-1:0]     hdr_chan_s;
  logic [N_PKTS_BITS-1:0]   hdr_len_s;
  logic                     chan_ok_s;
  logic                     word_done_s;
  logic                     bad_len_s;
  logic                     bad_chan_s;
  logic                     drop_s;
  logic                     af_s;
  logic [ERR_W-1:0]         err_evt_s;
  logic [N_CHAN-1:0]        push_s, pop_s, full_s, valid_s;
  logic [OCC_W-1:0]         occ_s [N_CHAN];
  logic [N_CHAN*PAYLOAD_WIDTH-1:0] payload_s;

  assign hdr_valid_s = bus.packet_i[HDR_VALID_BIT];
  assign hdr_chan_s  = bus.packet_i[HDR_CHAN_LSB +: CHAN_BITS];
  assign hdr_len_s   = bus.packet_i[LEN_LSB +: N_PKTS_BITS];
  assign chan_ok_s   = (int'(hdr_chan_s) < N_CHAN);

  // FSM next state, counters and assembly register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    chan_d      = chan_q;
    asm_d       = asm_q;
    word_done_s = 1'b0;
    bad_len_s   = 1'b0;
    bad_chan_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hdr_valid_s) begin
          state_d = IDLE;
        end else if (hdr_len_s == '0) begin
          bad_len_s = 1'b1;
        end else if (chan_ok_s && (hdr_len_s == N_PKTS_BITS'(N_PKTS))) begin
          state_d = ASSEMBLE;
          cnt_d   = hdr_len_s;
          idx_d   = '0;
          chan_d  = hdr_chan_s;
        end else begin
          // Bad header still announces its length, so swallow that many packets.
          state_d    = DISCARD;
          cnt_d      = hdr_len_s;
          bad_chan_s = !chan_ok_s;
          bad_len_s  = (hdr_len_s != N_PKTS_BITS'(N_PKTS));
        end
      end
      ASSEMBLE: begin
        asm_d[idx_q*PACKET_WIDTH +: PACKET_WIDTH] = bus.packet_i;
        idx_d = idx_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == N_PKTS_BITS'(1)) begin
          // Last packet: push the word including this cycle's packet.
          word_done_s = 1'b1;
          state_d     = IDLE;
          idx_d       = '0;
        end else begin
          state_d = ASSEMBLE;
        end
      end
      DISCARD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == N_PKTS_BITS'(1)) state_d = IDLE;
        else                          state_d = DISCARD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Push steering, overflow detection and almost-full.
  always_comb begin
    push_s = '0;
    pop_s  = '0;
    drop_s = 1'b0;
    af_s   = 1'b0;
    for (int c = 0; c < N_CHAN; c++) begin
      logic             sel_v;
      logic [OCC_W:0]   sum_v;
      pop_s[c]  = valid_s[c] && bus.payload_ready_i[c];
      sel_v     = word_done_s && (int'(chan_q) == c);
      // A full buffer still accepts when it pops in the same cycle.
      push_s[c] = sel_v && (!full_s[c] || pop_s[c]);
      drop_s    = drop_s || (sel_v && full_s[c] && !pop_s[c]);
      sum_v     = {1'b0, occ_s[c]} +
                  {{OCC_W{1'b0}}, ((state_q == ASSEMBLE) && (int'(chan_q) == c))};
      if (sum_v >= (OCC_W+1)'(DEPTH - AF_LVL)) af_s = 1'b1;
      else                                      af_s = af_s;
    end
  end

  assign err_evt_s = {drop_s, bad_chan_s, bad_len_s};

  // Sticky error flags; clear has priority, mask removes them when disabled.
  always_comb begin
    if (bus.err_clr_i) err_d = '0;
    else               err_d = (err_q | err_evt_s) & ERR_MASK;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      asm_q   <= '0;
      recv_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      asm_q   <= asm_d;
      recv_q  <= |push_s;
      err_q   <= err_d;
    end
  end

`ifdef DEPACK_ERR_STATUS_EN
`ifndef SYNTHESIS
  // Simulation report of each error event.
  always_ff @(posedge clk) begin
    if (!reset && (|err_evt_s)) begin
      $display("depacketizer_mc: error %b chan %0d n_pkts %0d", err_evt_s,
               drop_s ? int'(chan_q) : int'(hdr_chan_s),
               drop_s ? N_PKTS : int'(hdr_len_s));
    end
  end
`endif
`endif

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    depack_chan_fifo #(
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
      .DEPTH         (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s[c]),
      .data_i  (asm_d),
      .pop_i   (pop_s[c]),
      .data_o  (payload_s[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .valid_o (valid_s[c]),
      .full_o  (full_s[c]),
      .occ_o   (occ_s[c])
    );
  end

  assign bus.payload_o         = payload_s;
  assign bus.payload_valid_o   = valid_s;
  assign bus.packet_af_o       = af_s;
  assign bus.packet_received_o = recv_q;
  assign bus.err_o             = err_q;

endmodule
